// File: rtl/down_counter_timer_if.sv
// Control and status bundle for the down-counter/timer.
// The master drives load/enable/mode; the slave (the timer) returns count, pulse and busy.
interface down_counter_timer_if #(
    parameter int WIDTH = 8
);
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic             en_i;
    logic             auto_reload_i;
    logic [WIDTH-1:0] q_o;
    logic             tc_o;
    logic             busy_o;

    modport master (
        output load_i, load_val_i, en_i, auto_reload_i,
        input  q_o, tc_o, busy_o
    );

    modport slave (
        input  load_i, load_val_i, en_i, auto_reload_i,
        output q_o, tc_o, busy_o
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with a one-cycle terminal-count pulse and
// optional auto-reload; never wraps below zero.
module down_counter_timer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    down_counter_timer_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (bus.load_i) begin
            // A load always wins and suppresses any expiry on this edge.
            count_d  = bus.load_val_i;
            reload_d = bus.load_val_i;
            state_d  = (bus.load_val_i != ZERO) ? RUN : IDLE;
        end else if (state_q == RUN && bus.en_i) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else if (count_q == ONE) begin
                tc_d = 1'b1;
                if (bus.auto_reload_i) begin
                    count_d = reload_q;
                end else begin
                    count_d = ZERO;
                    state_d = IDLE;
                end
            end else begin
                // Zero in RUN is unreachable; fall back to IDLE rather than wrap.
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        bus.q_o    = count_q;
        bus.tc_o   = tc_q;
        bus.busy_o = (state_q == RUN);
    end
endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: vector table, directed corner
// sequences and randomized traffic against an elapsed-count reference model.
module tb_down_counter_timer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    down_counter_timer_if #(.WIDTH(8)) bus ();

    down_counter_timer #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] val;
        logic       en;
        logic       ar;
        logic [7:0] eq;
        logic       etc;
        logic       eb;
    } vec_t;

    vec_t tbl [23];

    // Reference model: period length and enabled edges elapsed since the last (re)start.
    int m_n, m_e, m_act, m_tc;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [7:0] val, input logic en, input logic ar);
        bus.load_i        = ld;
        bus.load_val_i    = val;
        bus.en_i          = en;
        bus.auto_reload_i = ar;
    endtask

    task automatic model_reset();
        m_n = 0; m_e = 0; m_act = 0; m_tc = 0;
    endtask

    task automatic model_edge(input logic ld, input int val, input logic en, input logic ar);
        m_tc = 0;
        if (ld) begin
            m_n = val; m_e = 0; m_act = (val != 0);
        end else if (m_act != 0 && en) begin
            m_e++;
            if (m_e == m_n) begin
                m_tc = 1;
                if (ar) m_e = 0;
                else    m_act = 0;
            end
        end
    endtask

    function automatic int model_q();
        return (m_act != 0) ? (m_n - m_e) : 0;
    endfunction

    initial begin
        int tc_cnt;
        int edges;
        int saw255;
        logic       r_ld, r_en, r_ar;
        logic [7:0] r_val;

        n_checks = 0;
        n_fail   = 0;
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        rst_n = 1'b0;

        tbl[0]  = '{1'b1, 8'd5,  1'b0, 1'b0, 8'd5,  1'b0, 1'b1};
        tbl[1]  = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd4,  1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd3,  1'b0, 1'b1};
        tbl[3]  = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd2,  1'b0, 1'b1};
        tbl[4]  = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd1,  1'b0, 1'b1};
        tbl[5]  = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd0,  1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd0,  1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'd4,  1'b0, 1'b0, 8'd4,  1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd3,  1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'd0,  1'b0, 1'b0, 8'd3,  1'b0, 1'b1};
        tbl[10] = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd2,  1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'd0,  1'b0, 1'b0, 8'd2,  1'b0, 1'b1};
        tbl[12] = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd1,  1'b0, 1'b1};
        tbl[13] = '{1'b0, 8'd0,  1'b0, 1'b0, 8'd1,  1'b0, 1'b1};
        tbl[14] = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd0,  1'b1, 1'b0};
        tbl[15] = '{1'b0, 8'd0,  1'b0, 1'b0, 8'd0,  1'b0, 1'b0};
        tbl[16] = '{1'b1, 8'd2,  1'b0, 1'b1, 8'd2,  1'b0, 1'b1};
        tbl[17] = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd1,  1'b0, 1'b1};
        tbl[18] = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd2,  1'b1, 1'b1};
        tbl[19] = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd1,  1'b0, 1'b1};
        tbl[20] = '{1'b1, 8'd10, 1'b1, 1'b1, 8'd10, 1'b0, 1'b1};
        tbl[21] = '{1'b1, 8'd0,  1'b1, 1'b1, 8'd0,  1'b0, 1'b0};
        tbl[22] = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd0,  1'b0, 1'b0};

        // Power-on reset state
        #12;
        check("reset_q", int'(bus.q_o), 0);
        check("reset_tc", int'(bus.tc_o), 0);
        check("reset_busy", int'(bus.busy_o), 0);
        rst_n = 1'b1;
        tick();

        // Async reset mid-count after a load of 200
        drive(1'b1, 8'd200, 1'b0, 1'b0);
        tick();
        check("load200_q", int'(bus.q_o), 200);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        tick();
        check("load200_dec_q", int'(bus.q_o), 199);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q", int'(bus.q_o), 0);
        check("async_rst_busy", int'(bus.busy_o), 0);
        check("async_rst_tc", int'(bus.tc_o), 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_q", int'(bus.q_o), 0);
            check("post_rst_busy", int'(bus.busy_o), 0);
            check("post_rst_tc", int'(bus.tc_o), 0);
        end

        // Vector table: one-shot, enable gaps, periodic, load priority, zero load
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].ld, tbl[i].val, tbl[i].en, tbl[i].ar);
            tick();
            $display("vec %0d: ld=%0d val=%0d en=%0d ar=%0d -> q=%0d tc=%0d busy=%0d", i,
                     tbl[i].ld, tbl[i].val, tbl[i].en, tbl[i].ar, bus.q_o, bus.tc_o, bus.busy_o);
            check("vec_q", int'(bus.q_o), int'(tbl[i].eq));
            check("vec_tc", int'(bus.tc_o), int'(tbl[i].etc));
            check("vec_busy", int'(bus.busy_o), int'(tbl[i].eb));
        end

        // One-shot hold: q stays at 0 for 10 more enabled cycles
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'd0, 1'b1, 1'b0);
            tick();
            check("idle_hold_q", int'(bus.q_o), 0);
        end

        // Periodic load 3, 12 enabled cycles -> 4 pulses
        drive(1'b1, 8'd3, 1'b0, 1'b1);
        tick();
        check("per_load_q", int'(bus.q_o), 3);
        tc_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 8'd0, 1'b1, 1'b1);
            tick();
            if (bus.tc_o) tc_cnt++;
            check("per_q", int'(bus.q_o), 3 - (k % 3));
            check("per_tc", int'(bus.tc_o), ((k % 3) == 0) ? 1 : 0);
        end
        check("per_tc_count", tc_cnt, 4);

        // Max value 255 one-shot: expiry after exactly 255 edges, no wrap
        drive(1'b1, 8'd255, 1'b0, 1'b0);
        tick();
        check("max_load_q", int'(bus.q_o), 255);
        edges  = 0;
        saw255 = 0;
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        while (edges < 300) begin
            tick();
            edges++;
            if (bus.q_o == 8'd255) saw255 = 1;
            if (bus.tc_o) break;
        end
        check("max_edges", edges, 255);
        check("max_no_wrap", saw255, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("max_after_q", int'(bus.q_o), 0);
            check("max_after_busy", int'(bus.busy_o), 0);
        end

        // Randomized traffic against the reference model
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            r_ld  = ($urandom_range(0, 15) == 0);
            r_val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 6));
            r_en  = ($urandom_range(0, 3) != 0);
            r_ar  = 1'($urandom_range(0, 1));
            drive(r_ld, r_val, r_en, r_ar);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check("rnd_rst_q", int'(bus.q_o), 0);
                check("rnd_rst_busy", int'(bus.busy_o), 0);
                #1;
                rst_n = 1'b1;
            end
            tick();
            model_edge(r_ld, int'(r_val), r_en, r_ar);
            check("rnd_q", int'(bus.q_o), model_q());
            check("rnd_tc", int'(bus.tc_o), m_tc);
            check("rnd_busy", int'(bus.busy_o), (m_act != 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
